// File: rtl/wb_arbiter_pkg.sv
// Shared constants, bus payload and source encodings for the writeback arbiter.
package wb_arbiter_pkg;

  localparam int unsigned DEPTH = 2;   // LU result buffer entries (power of two, >= 2)
  localparam int unsigned DW    = 32;  // data width
  localparam int unsigned AW    = 5;   // register index width
  localparam int unsigned CW    = $clog2(DEPTH) + 1;  // buffer occupancy width
  localparam int unsigned NREG  = 32'(1) << AW;       // architectural register count

  localparam logic [AW-1:0] REG_ZERO = '0;  // index 0 means "no write"

  // One buffered long-latency result
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  // Which source owns the register-file write port this cycle
  typedef enum logic [1:0] {
    WB_SRC_NONE   = 2'd0,
    WB_SRC_PIPE   = 2'd1,
    WB_SRC_FIFO   = 2'd2,
    WB_SRC_BYPASS = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Compacting LU result buffer with per-entry destination-match squash.
// Entry 0 is always the head; surviving entries shift down every cycle.
// Optional: WB_PENDING_EN adds pending_mask (one bit per buffered destination).
module wb_fifo
  import wb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_rd,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          squash,
  input  logic [AW-1:0] squash_rd,
  output logic [AW-1:0] head_rd,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count
`ifdef WB_PENDING_EN
  ,
  output logic [NREG-1:0] pending_mask
`endif
);

  wb_entry_t     ent_q [DEPTH];
  wb_entry_t     ent_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  int unsigned   fill;

  // Drop popped/squashed entries, compact survivors toward the head, append push
  always_comb begin
    fill = 0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      ent_d[j] = '0;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && !(pop && (i == 0)) &&
          !(squash && (ent_q[i].rd == squash_rd))) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          if (j == fill) ent_d[j] = ent_q[i];
        end
        fill = fill + 1;
      end
    end
    if (push) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j == fill) ent_d[j] = '{valid: 1'b1, rd: push_rd, data: push_data};
      end
      fill = fill + 1;
    end
    count_d = CW'(fill);
  end

  // Buffer storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

  assign head_rd   = ent_q[0].rd;
  assign head_data = ent_q[0].data;
  assign count     = count_q;

`ifdef WB_PENDING_EN
  // One bit per register targeted by a live buffered entry
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) pending_mask[ent_q[i].rd] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority,
// long-latency results bypass into idle slots or wait in wb_fifo.
// Optional: WB_PENDING_EN adds the pending_mask output.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_rd,
  input  logic [DW-1:0] pipe_data,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_rd,
  input  logic [DW-1:0] lu_data,
  output logic [AW-1:0] rwd,
  output logic [DW-1:0] wb_data,
  output logic [CW-1:0] buf_count
`ifdef WB_PENDING_EN
  ,
  output logic [NREG-1:0] pending_mask
`endif
);

  logic          pipe_own_c;
  logic          lu_fire_c;
  logic          lu_live_c;
  logic          fifo_pop_c;
  logic          fifo_push_c;
  wb_src_e       src_c;
  logic          ready_en_q;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;
  logic [AW-1:0] rwd_q;
  logic [DW-1:0] wb_data_q;

  wb_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push_c),
    .push_rd   (lu_rd),
    .push_data (lu_data),
    .pop       (fifo_pop_c),
    .squash    (pipe_own_c),
    .squash_rd (pipe_rd),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (buf_count)
`ifdef WB_PENDING_EN
    ,
    .pending_mask (pending_mask)
`endif
  );

  // Ready comes up on the first edge after reset release; drops only when full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  assign lu_ready = ready_en_q && rst_n && (buf_count < CW'(DEPTH));

  // Slot ownership: pipe first, then buffered head, then direct LU bypass
  always_comb begin
    src_c       = WB_SRC_NONE;
    fifo_pop_c  = 1'b0;
    fifo_push_c = 1'b0;
    pipe_own_c  = pipe_we && (pipe_rd != REG_ZERO);
    lu_fire_c   = lu_valid && lu_ready;
    // Discard rd==0 results and results overwritten by the younger pipe write
    lu_live_c   = lu_fire_c && (lu_rd != REG_ZERO) &&
                  !(pipe_own_c && (lu_rd == pipe_rd));
    if (pipe_own_c) begin
      src_c       = WB_SRC_PIPE;
      fifo_push_c = lu_live_c;
    end else if (buf_count != '0) begin
      src_c       = WB_SRC_FIFO;
      fifo_pop_c  = 1'b1;
      fifo_push_c = lu_live_c;
    end else if (lu_live_c) begin
      src_c       = WB_SRC_BYPASS;
    end
  end

  // Write-port registers; data holds when the slot goes unused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rwd_q     <= REG_ZERO;
      wb_data_q <= '0;
    end else begin
      case (src_c)
        WB_SRC_PIPE: begin
          rwd_q     <= pipe_rd;
          wb_data_q <= pipe_data;
        end
        WB_SRC_FIFO: begin
          rwd_q     <= head_rd;
          wb_data_q <= head_data;
        end
        WB_SRC_BYPASS: begin
          rwd_q     <= lu_rd;
          wb_data_q <= lu_data;
        end
        default: begin
          rwd_q     <= REG_ZERO;
        end
      endcase
    end
  end

  assign rwd     = rwd_q;
  assign wb_data = wb_data_q;

endmodule
